// File: rtl/mem_transfer_pkg.sv
// Shared state type, constants and sizing helpers for mem_transfer_unit.
package mem_transfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MEM_CS_ACTIVE = 1'b0;
  localparam int   BYTE_W        = 8;

  function automatic int bytes_of(input int data_width);
    return data_width / BYTE_W;
  endfunction

  // The Size field stays at least one bit wide even for a single-byte datapath.
  function automatic int size_width(input int data_width);
    if (bytes_of(data_width) > 1) return $clog2(bytes_of(data_width));
    else return 1;
  endfunction

endpackage

// File: rtl/mem_transfer_unit_byte_lane_select.sv
// Parametrised DATA_WIDTH-to-8 byte multiplexer feeding the memory data lane.
module byte_lane_select
  import mem_transfer_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  localparam int NB         = bytes_of(DATA_WIDTH),
  localparam int SW         = size_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [SW-1:0]         sel,
  output logic [BYTE_W-1:0]     lane
);

  // AND-OR mux so a select beyond the last lane yields zero rather than an X slice.
  always_comb begin
    lane = {BYTE_W{1'b0}};
    for (int i = 0; i < NB; i++) begin
      lane = lane | (data[i*BYTE_W +: BYTE_W] & {BYTE_W{sel == SW'(i)}});
    end
  end

endmodule

// File: rtl/mem_transfer_unit.sv
// Multi-byte load/store sequencer between a DATA_WIDTH register and byte-wide memory.
// Optional sign extension of loads is enabled with `define MEM_TRANSFER_SIGN_EXT_EN.
module mem_transfer_unit
  import mem_transfer_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 16,
  localparam int NB         = bytes_of(DATA_WIDTH),
  localparam int SW         = size_width(DATA_WIDTH)
) (
`ifdef MEM_TRANSFER_SIGN_EXT_EN
  input  logic                  LoadSigned,
`endif
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Write,
  input  logic [SW-1:0]         Size,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic [DATA_WIDTH-1:0] WData,
  output logic [DATA_WIDTH-1:0] RData,
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [BYTE_W-1:0]     Mem_Data,
  output logic                  Mem_WR,
  output logic                  Mem_CS,
  input  logic [BYTE_W-1:0]     MemOut
);

  state_t                  state_r;
  logic                    write_r;
  logic [SW-1:0]           size_r;
  logic [SW-1:0]           k_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
`ifdef MEM_TRANSFER_SIGN_EXT_EN
  logic                    sign_r;
`endif

  logic                    accept_s;
  logic [SW-1:0]           k_next_s;
  logic [DATA_WIDTH-1:0]   lane_src_s;
  logic [SW-1:0]           lane_sel_s;
  logic [BYTE_W-1:0]       lane_s;

  assign accept_s = Start && (state_r != XFER);
  assign k_next_s = k_r + SW'(1);

  // Memory outputs are registered one edge ahead, so the mux looks at the byte of the next cycle.
  assign lane_src_s = accept_s ? WData : wdata_r;
  assign lane_sel_s = accept_s ? {SW{1'b0}} : k_next_s;

  byte_lane_select #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .data (lane_src_s),
    .sel  (lane_sel_s),
    .lane (lane_s)
  );

  // Transfer FSM with all outputs registered.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= IDLE;
      write_r     <= 1'b0;
      size_r      <= {SW{1'b0}};
      k_r         <= {SW{1'b0}};
      base_r      <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= {DATA_WIDTH{1'b0}};
`ifdef MEM_TRANSFER_SIGN_EXT_EN
      sign_r      <= 1'b0;
`endif
      RData       <= {DATA_WIDTH{1'b0}};
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Mem_Address <= {ADDR_WIDTH{1'b0}};
      Mem_Data    <= {BYTE_W{1'b0}};
      Mem_WR      <= 1'b0;
      Mem_CS      <= ~MEM_CS_ACTIVE;
    end else if (accept_s) begin
      write_r     <= Write;
      size_r      <= Size;
      k_r         <= {SW{1'b0}};
      base_r      <= BaseAddr;
      wdata_r     <= WData;
`ifdef MEM_TRANSFER_SIGN_EXT_EN
      sign_r      <= LoadSigned;
`endif
      if (!Write) RData <= {DATA_WIDTH{1'b0}};
      if (Write) Mem_Data <= lane_s;
      state_r     <= XFER;
      Busy        <= 1'b1;
      Done        <= 1'b0;
      Mem_CS      <= MEM_CS_ACTIVE;
      Mem_WR      <= Write;
      Mem_Address <= BaseAddr;
    end else begin
      case (state_r)
        XFER: begin
          if (!write_r) begin
            for (int i = 0; i < NB; i++) begin
              if (k_r == SW'(i)) RData[i*BYTE_W +: BYTE_W] <= MemOut;
            end
          end
          if (k_r == size_r) begin
            state_r <= DONE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            Mem_CS  <= ~MEM_CS_ACTIVE;
            Mem_WR  <= 1'b0;
`ifdef MEM_TRANSFER_SIGN_EXT_EN
            // The top loaded byte arrives on this same edge, so its MSB is MemOut[7].
            if (!write_r && sign_r) begin
              for (int i = 0; i < NB; i++) begin
                if (i > int'(size_r)) RData[i*BYTE_W +: BYTE_W] <= {BYTE_W{MemOut[7]}};
              end
            end
`endif
          end else begin
            k_r         <= k_next_s;
            Mem_Address <= base_r + ADDR_WIDTH'(k_next_s);
            if (write_r) Mem_Data <= lane_s;
          end
        end
        DONE: begin
          state_r <= IDLE;
          Done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
          Mem_CS  <= ~MEM_CS_ACTIVE;
          Mem_WR  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_transfer_unit.sv
// Self-checking bench for mem_transfer_unit with a byte-array memory and a reference model.
module tb_mem_transfer_unit;
  localparam int DW = 32;
  localparam int AW = 16;

  logic          Clock = 1'b0;
  logic          Reset, Start, Write;
  logic [1:0]    Size;
  logic [AW-1:0] BaseAddr, Mem_Address;
  logic [DW-1:0] WData, RData;
  logic          Busy, Done, Mem_WR, Mem_CS;
  logic [7:0]    Mem_Data, MemOut;
  logic          load_signed;

  logic          poke_en;
  logic [15:0]   poke_a;
  logic [7:0]    poke_d;
  logic [7:0]    mem [65536];
  bit            written [65536];
  logic [7:0]    ref_mem [65536];
  logic [31:0]   model_rdata;

  int            total = 0;
  int            bad = 0;
  logic [15:0]   addr_q [$];
  logic [7:0]    data_q [$];
  int            wr_cnt, busy_cnt, done_cyc;
  bit            cs_bad;
  logic [31:0]   obs_rdata;

  always #5 Clock = ~Clock;

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return written[a] ? mem[a] : dflt(a);
  endfunction

  assign MemOut = written[Mem_Address] ? mem[Mem_Address] : dflt(Mem_Address);

  always @(posedge Clock) begin
    if (poke_en) begin
      mem[poke_a] <= poke_d;
      written[poke_a] <= 1'b1;
    end else if (Mem_CS == 1'b0 && Mem_WR == 1'b1) begin
      mem[Mem_Address] <= Mem_Data;
      written[Mem_Address] <= 1'b1;
    end
  end

  mem_transfer_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
`ifdef MEM_TRANSFER_SIGN_EXT_EN
    .LoadSigned  (load_signed),
`endif
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Write       (Write),
    .Size        (Size),
    .BaseAddr    (BaseAddr),
    .WData       (WData),
    .RData       (RData),
    .Busy        (Busy),
    .Done        (Done),
    .Mem_Address (Mem_Address),
    .Mem_Data    (Mem_Data),
    .Mem_WR      (Mem_WR),
    .Mem_CS      (Mem_CS),
    .MemOut      (MemOut)
  );

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge Clock);
    poke_en = 1'b1; poke_a = a; poke_d = d; ref_mem[a] = d;
    @(negedge Clock);
    poke_en = 1'b0;
  endtask

  // Reference: stores write consecutive little-endian bytes, loads assemble them.
  task automatic model_transfer(input logic w, input logic [1:0] sz, input logic [15:0] base,
                                input logic [31:0] wd, input logic ls);
    int n;
    n = int'(sz) + 1;
    if (w) begin
      for (int i = 0; i < n; i++) ref_mem[base + 16'(i)] = wd[8*i +: 8];
    end else begin
      model_rdata = 32'h0;
      for (int i = 0; i < n; i++) model_rdata = model_rdata | (32'(ref_mem[base + 16'(i)]) << (8*i));
      if (ls && model_rdata[8*n-1]) model_rdata = model_rdata | ~((32'h1 << (8*n)) - 32'h1);
    end
  endtask

  task automatic run_transfer(input logic w, input logic [1:0] sz, input logic [15:0] base,
                              input logic [31:0] wd, input logic ls, input int glitch_cyc);
    addr_q.delete(); data_q.delete();
    wr_cnt = 0; busy_cnt = 0; done_cyc = -1; cs_bad = 1'b0; obs_rdata = 32'h0;
    @(negedge Clock);
    Start = 1'b1; Write = w; Size = sz; BaseAddr = base; WData = wd; load_signed = ls;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clock);
      if (c == 1) Start = 1'b0;
      if (Busy === 1'b1) begin
        addr_q.push_back(Mem_Address);
        data_q.push_back(Mem_Data);
        busy_cnt++;
        if (Mem_WR === 1'b1) wr_cnt++;
        if (Mem_CS !== 1'b0) cs_bad = 1'b1;
      end else if (Mem_CS !== 1'b1 || Mem_WR !== 1'b0) begin
        cs_bad = 1'b1;
      end
      if (Done === 1'b1 && done_cyc < 0) begin
        done_cyc = c;
        obs_rdata = RData;
      end
      if (c == glitch_cyc) begin
        Start = 1'b1; Write = ~w; BaseAddr = ~base; WData = ~wd;
      end else if (c == glitch_cyc + 1) begin
        Start = 1'b0;
      end
      if (done_cyc > 0) break;
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Write = 1'b0; Size = 2'd0; BaseAddr = 16'h0;
    WData = 32'h0; load_signed = 1'b0; poke_en = 1'b0; poke_a = 16'h0; poke_d = 8'h0;
    repeat (3) @(negedge Clock);
    total++; if (RData !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", RData, 32'h0); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", Done); end
    total++; if (Mem_Address !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0000", Mem_Address); end
    total++; if (Mem_Data !== 8'h0) begin bad++; $display("FAIL reset_mdata got=%h exp=00", Mem_Data); end
    total++; if (Mem_WR !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", Mem_WR); end
    total++; if (Mem_CS !== 1'b1) begin bad++; $display("FAIL reset_cs got=%b exp=1", Mem_CS); end
    Reset = 1'b0;
  endtask

  task automatic test_load_basic();
    poke(16'h0010, 8'h11); poke(16'h0011, 8'h22); poke(16'h0012, 8'h33); poke(16'h0013, 8'h44);
    run_transfer(1'b0, 2'd3, 16'h0010, 32'h0, 1'b0, 0);
    model_transfer(1'b0, 2'd3, 16'h0010, 32'h0, 1'b0);
    total++; if (done_cyc !== 5) begin bad++; $display("FAIL load_done_cycle got=%0d exp=5", done_cyc); end
    total++; if (addr_q.size() !== 4) begin bad++; $display("FAIL load_busy_cycles got=%0d exp=4", addr_q.size()); end
    for (int i = 0; i < addr_q.size(); i++) begin
      total++;
      if (addr_q[i] !== 16'h0010 + 16'(i)) begin bad++; $display("FAIL load_addr[%0d] got=%h exp=%h", i, addr_q[i], 16'h0010 + 16'(i)); end
    end
    total++; if (wr_cnt !== 0 || cs_bad) begin bad++; $display("FAIL load_ctrl wr_cnt=%0d cs_bad=%0d exp 0/0", wr_cnt, cs_bad); end
    total++; if (obs_rdata !== 32'h44332211) begin bad++; $display("FAIL load_rdata got=%h exp=44332211", obs_rdata); end
    repeat (2) @(negedge Clock);
    total++; if (RData !== 32'h44332211 || Done !== 1'b0) begin bad++; $display("FAIL load_hold rdata=%h done=%b exp 44332211/0", RData, Done); end
  endtask

  task automatic test_store_basic();
    logic [7:0] before22;
    before22 = ref_mem[16'h0022];
    run_transfer(1'b1, 2'd1, 16'h0020, 32'hA1B2C3D4, 1'b0, 0);
    model_transfer(1'b1, 2'd1, 16'h0020, 32'hA1B2C3D4, 1'b0);
    total++; if (wr_cnt !== 2) begin bad++; $display("FAIL store_wr_cycles got=%0d exp=2", wr_cnt); end
    total++; if (done_cyc !== 3) begin bad++; $display("FAIL store_done_cycle got=%0d exp=3", done_cyc); end
    total++; if (mem_rd(16'h0020) !== 8'hD4) begin bad++; $display("FAIL store_m20 got=%h exp=d4", mem_rd(16'h0020)); end
    total++; if (mem_rd(16'h0021) !== 8'hC3) begin bad++; $display("FAIL store_m21 got=%h exp=c3", mem_rd(16'h0021)); end
    total++; if (mem_rd(16'h0022) !== before22) begin bad++; $display("FAIL store_m22 got=%h exp=%h", mem_rd(16'h0022), before22); end
    total++; if (obs_rdata !== 32'h44332211) begin bad++; $display("FAIL store_keeps_rdata got=%h exp=44332211", obs_rdata); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    exp = {16'h0, ref_mem[16'h0000], ref_mem[16'hFFFF]};
    run_transfer(1'b0, 2'd1, 16'hFFFF, 32'h0, 1'b0, 0);
    model_transfer(1'b0, 2'd1, 16'hFFFF, 32'h0, 1'b0);
    total++;
    if (addr_q.size() !== 2 || addr_q[0] !== 16'hFFFF || addr_q[1] !== 16'h0000) begin
      bad++; $display("FAIL wrap_addr n=%0d first=%h second=%h exp ffff,0000", addr_q.size(), addr_q[0], addr_q[1]);
    end
    total++; if (obs_rdata !== exp) begin bad++; $display("FAIL wrap_rdata got=%h exp=%h", obs_rdata, exp); end
  endtask

  task automatic test_ignore_start();
    run_transfer(1'b0, 2'd3, 16'h0100, 32'h0, 1'b0, 2);
    model_transfer(1'b0, 2'd3, 16'h0100, 32'h0, 1'b0);
    total++; if (done_cyc !== 5 || busy_cnt !== 4) begin bad++; $display("FAIL ignore_timing done=%0d busy=%0d exp 5/4", done_cyc, busy_cnt); end
    total++; if (addr_q.size() != 4 || addr_q[3] !== 16'h0103) begin bad++; $display("FAIL ignore_addr last=%h exp=0103", addr_q[addr_q.size()-1]); end
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL ignore_no_write got=%0d exp=0", wr_cnt); end
    total++; if (obs_rdata !== model_rdata) begin bad++; $display("FAIL ignore_rdata got=%h exp=%h", obs_rdata, model_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd;
    int first_done, second_done;
    wd = $urandom(); first_done = -1; second_done = -1; obs_rdata = 32'h0;
    @(negedge Clock);
    Start = 1'b1; Write = 1'b1; Size = 2'd0; BaseAddr = 16'h0200; WData = wd; load_signed = 1'b0;
    model_transfer(1'b1, 2'd0, 16'h0200, wd, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clock);
      if (c == 1) begin Write = 1'b0; Size = 2'd2; BaseAddr = 16'h0300; end
      if (Done === 1'b1 && first_done < 0) begin
        first_done = c;
      end else if (first_done > 0 && c == first_done + 1) begin
        total++;
        if (Busy !== 1'b1 || Mem_Address !== 16'h0300) begin
          bad++; $display("FAIL b2b_no_idle busy=%b addr=%h exp 1/0300", Busy, Mem_Address);
        end
        Start = 1'b0;
      end else if (Done === 1'b1 && first_done > 0 && second_done < 0) begin
        second_done = c; obs_rdata = RData;
      end
    end
    Start = 1'b0;
    model_transfer(1'b0, 2'd2, 16'h0300, 32'h0, 1'b0);
    total++; if (first_done !== 2 || second_done !== 6) begin bad++; $display("FAIL b2b_done first=%0d second=%0d exp 2/6", first_done, second_done); end
    total++; if (obs_rdata !== model_rdata) begin bad++; $display("FAIL b2b_rdata got=%h exp=%h", obs_rdata, model_rdata); end
    total++; if (mem_rd(16'h0200) !== wd[7:0]) begin bad++; $display("FAIL b2b_store got=%h exp=%h", mem_rd(16'h0200), wd[7:0]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] wd;
    bit saw_done;
    wd = {~ref_mem[16'h0403], ~ref_mem[16'h0402], 16'($urandom())};
    @(negedge Clock);
    Start = 1'b1; Write = 1'b1; Size = 2'd3; BaseAddr = 16'h0400; WData = wd;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    ref_mem[16'h0400] = wd[7:0]; ref_mem[16'h0401] = wd[15:8]; model_rdata = 32'h0;
    total++;
    if (Mem_CS !== 1'b1 || Busy !== 1'b0 || RData !== 32'h0 || Mem_WR !== 1'b0) begin
      bad++; $display("FAIL midrst_state cs=%b busy=%b rdata=%h wr=%b exp 1/0/0/0", Mem_CS, Busy, RData, Mem_WR);
    end
    saw_done = (Done === 1'b1);
    repeat (4) begin
      @(negedge Clock);
      if (Done === 1'b1 || Mem_CS !== 1'b1) saw_done = 1'b1;
    end
    total++; if (saw_done) begin bad++; $display("FAIL midrst_quiet got=activity exp=none"); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem_rd(16'h0400 + 16'(i)) !== ref_mem[16'h0400 + 16'(i)]) begin
        bad++; $display("FAIL midrst_mem[%0d] got=%h exp=%h", i, mem_rd(16'h0400 + 16'(i)), ref_mem[16'h0400 + 16'(i)]);
      end
    end
  endtask

  task automatic test_random();
    logic w, ls;
    logic [1:0] sz;
    logic [15:0] base;
    logic [31:0] wd;
    int n;
    for (int it = 0; it < 40; it++) begin
      w = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); wd = $urandom();
      base = (it % 5 == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom_range(0, 63) + 16'h0800);
`ifdef MEM_TRANSFER_SIGN_EXT_EN
      ls = 1'($urandom_range(0, 1));
`else
      ls = 1'b0;
`endif
      n = int'(sz) + 1;
      run_transfer(w, sz, base, wd, ls, 0);
      model_transfer(w, sz, base, wd, ls);
      total++; if (done_cyc !== n + 1) begin bad++; $display("FAIL rnd%0d_done got=%0d exp=%0d", it, done_cyc, n + 1); end
      total++; if (cs_bad || wr_cnt !== (w ? n : 0)) begin bad++; $display("FAIL rnd%0d_ctrl wr_cnt=%0d cs_bad=%0d exp %0d/0", it, wr_cnt, cs_bad, w ? n : 0); end
      if (addr_q.size() == n) begin
        for (int i = 0; i < n; i++) begin
          total++;
          if (addr_q[i] !== base + 16'(i)) begin bad++; $display("FAIL rnd%0d_addr[%0d] got=%h exp=%h", it, i, addr_q[i], base + 16'(i)); end
          if (w) begin
            total++;
            if (data_q[i] !== wd[8*i +: 8] || mem_rd(base + 16'(i)) !== ref_mem[base + 16'(i)]) begin
              bad++; $display("FAIL rnd%0d_store[%0d] bus=%h mem=%h exp=%h", it, i, data_q[i], mem_rd(base + 16'(i)), ref_mem[base + 16'(i)]);
            end
          end
        end
      end else begin
        total++; bad++; $display("FAIL rnd%0d_cycles got=%0d exp=%0d", it, addr_q.size(), n);
      end
      total++; if (obs_rdata !== model_rdata) begin bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", it, obs_rdata, model_rdata); end
    end
  endtask

`ifdef MEM_TRANSFER_SIGN_EXT_EN
  task automatic test_sign_ext();
    poke(16'h0030, 8'h80);
    run_transfer(1'b0, 2'd0, 16'h0030, 32'h0, 1'b1, 0);
    total++; if (obs_rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL sext_signed got=%h exp=ffffff80", obs_rdata); end
    run_transfer(1'b0, 2'd0, 16'h0030, 32'h0, 1'b0, 0);
    total++; if (obs_rdata !== 32'h00000080) begin bad++; $display("FAIL sext_unsigned got=%h exp=00000080", obs_rdata); end
    model_rdata = 32'h00000080;
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = dflt(16'(i));
    model_rdata = 32'h0;
    test_reset();
    test_load_basic();
    test_store_basic();
    test_wrap();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MEM_TRANSFER_SIGN_EXT_EN
    test_sign_ext();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
